e203_clkgate_ctrl: RTL
======================

# e203_clkgate_ctrl

Parametrised multi-channel clock-gating controller for the E203 core and its peripheral subsystems. Each of NCH channels owns an idle-detect counter, a four-state gating FSM, a four-phase wake request/acknowledge handshake and a glitch-free latch-based gate cell. Gating is enabled per channel at run time. The block sits between the free-running core clock and the per-unit clock roots.

## Interface
- NCH, 4: number of gated clock channels (1..16).
- IDLE_W, 8: width of the idle threshold and idle counter.
- WAKE_CYC, 2: clock cycles spent in WAKE before the channel is declared stable (≥1).
- clk  in  1  free-running source clock; FSMs and counters run on it, never on a gated output.
- rst  in  1  reset, asynchronous, active-high.
- test_mode  in  1  forces every gate transparent and forces every FSM out of OFF.
- cfg_en  in  NCH  per-channel gating permission; 0 keeps the channel clocked.
- cfg_idle_thr  in  IDLE_W  idle cycles tolerated before gating; shared by all channels; sampled live.
- ch_busy  in  NCH  unit activity; 1 = unit needs its clock.
- ch_wreq  in  NCH  wake request, level, held until ch_wack.
- ch_wack  out  NCH  channel clock running and stable.
- ch_gated  out  NCH  channel clock currently gated.
- clk_out  out  NCH  gated clocks.

## Operation
- Per-channel FSM states: ON, IDLE, OFF, WAKE. Reset state is ON.
- ON:
  - cfg_en & !ch_busy & !ch_wreq & !test_mode → IDLE, with cnt cleared to 0.
- IDLE (clock running):
  - ch_busy | ch_wreq | !cfg_en | test_mode → ON; this exit has priority.
  - Otherwise, if cnt ≥ cfg_idle_thr → OFF; else cnt++.
- OFF (clock gated):
  - ch_busy | ch_wreq | !cfg_en | test_mode → WAKE, with wcnt cleared to 0.
- WAKE (clock running):
  - wcnt == WAKE_CYC-1 → ON; else wcnt++.
  - Inputs are ignored in WAKE; the channel always completes WAKE.
- Gate enable: gate_en = (next_state != OFF), registered on clk, reset value 1.
- Gate cell output: clk_out = (latched(gate_en | test_mode) while clk low) & clk.
- ch_wack = state ∈ {ON, IDLE}, registered. ch_gated = (state == OFF), registered.
- Handshake: a requester raises ch_wreq and holds it until ch_wack = 1. While ch_wreq = 1 the channel cannot leave ON. Dropping ch_wreq has no other effect.
- Counter width rule:
  - cnt is IDLE_W bits and never exceeds cfg_idle_thr. The ≥ compare makes it saturate rather than wrap.
  - Lowering cfg_idle_thr below the current cnt sends the channel to OFF on the next edge.
- cfg_idle_thr = 0: the channel gates one edge after entering IDLE.
- Channels are fully independent; simultaneous events on different channels never interact.
- FPGA_SOURCE build: the cell degenerates to clk_out = clk. The FSM, ch_wack and ch_gated still operate.

## Timing
- Reset values: state ON, cnt 0, wcnt 0, gate_en 1, ch_wack 0, ch_gated 0.
- ch_wack rises on the first edge after rst deasserts.
- Asserting rst mid-operation, including in OFF, is asynchronous: the next high phase of clk appears on clk_out.
- Gating latency: ch_busy falls and is sampled at edge k.
  - IDLE after edge k.
  - OFF after edge k+T+1, where T = cfg_idle_thr.
  - The last clk_out rising edge is edge k+T+1.
  - The first suppressed edge is k+T+2.
- Wake latency: the wake cause is sampled at edge m while in OFF.
  - WAKE after edge m; clk_out pulses from edge m+1.
  - ON and ch_wack = 1 after edge m+WAKE_CYC.
- test_mode: clk_out is ungated from the next clk low phase, independent of the FSM.
- The gate is glitch-free. gate_en changes only on the rising edge, and the latch is closed during the high phase.

## Structure
- Package e203_clkgate_pkg holds:
  - typedef enum logic [1:0] cg_state_e {CG_ON, CG_IDLE, CG_OFF, CG_WAKE};
  - localparam for the WAKE counter width, $clog2(WAKE_CYC+1).
- Sub-module e203_clkgate_cell (clk_in, test_mode, clock_en, clk_out) is instantiated NCH times via generate.
  - It contains the latch and AND, and the FPGA_SOURCE bypass.
- The FSM, counters and status registers are implemented inline in a generate loop.

## Test plan
- Reset, NCH=4: assert rst mid-cycle → clk_out follows clk on all channels, ch_wack=0, ch_gated=0; release → ch_wack=4'hF after one edge.
- cfg_en=4'h1, cfg_idle_thr=3, ch_busy[0] drops at edge 10 → ch_gated[0]=1 after edge 14, no clk_out[0] rising edge from edge 15 on; channels 1–3 keep toggling.
- Ch0 in OFF, ch_wreq[0] rises at edge 20 → clk_out[0] resumes at edge 21; ch_wack[0]=1 after edge 22 (WAKE_CYC=2); hold ch_wreq 10 cycles → ch0 stays ON.
- In IDLE with cnt=2, lower cfg_idle_thr to 1 → OFF after the next edge; cfg_idle_thr=0 → OFF one edge after entering IDLE.
- Ch0 OFF, assert test_mode → clk_out[0] ungated from the next low phase, FSM passes through WAKE to ON, IDLE is never entered while test_mode=1.
- Glitch check: toggle ch_busy and cfg_en asynchronously to clk → no clk_out pulse narrower than the clk high phase on any channel.

Source files
------------

// File: rtl/e203_clkgate_pkg.sv
// Shared types and sizing helpers for the E203 multi-channel clock-gating controller.
package e203_clkgate_pkg;

  typedef enum logic [1:0] {
    CG_ON   = 2'd0,
    CG_IDLE = 2'd1,
    CG_OFF  = 2'd2,
    CG_WAKE = 2'd3
  } cg_state_e;

  localparam int unsigned CG_WAKE_CYC = 2;
  localparam int unsigned CG_WCNT_W   = $clog2(CG_WAKE_CYC + 1);

  // Wake counter width for an arbitrary WAKE_CYC; the default build reuses CG_WCNT_W.
  function automatic int unsigned cg_wcnt_w(input int unsigned wake_cyc);
    return (wake_cyc == CG_WAKE_CYC) ? CG_WCNT_W : 32'($clog2(wake_cyc + 1));
  endfunction

endpackage

// File: rtl/e203_clkgate_cell.sv
// Glitch-free clock gate: enable captured by a latch that is transparent only while clk_in is low.
module e203_clkgate_cell (
  input  logic clk_in,
  input  logic test_mode,
  input  logic clock_en,
  output logic clk_out
);

`ifdef FPGA_SOURCE
  assign clk_out = clk_in;
`else
  logic en_lat;

  // Closed during the high phase, so enable changes at the rising edge cannot chop a pulse.
  always_latch begin
    if (!clk_in) begin
      en_lat = clock_en | test_mode;
    end
  end

  assign clk_out = en_lat & clk_in;
`endif

endmodule

// File: rtl/e203_clkgate_ctrl.sv
// Per-channel idle detection, gating FSM and wake handshake driving one gate cell per clock root.
module e203_clkgate_ctrl
  import e203_clkgate_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = CG_WAKE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_mode,
  input  logic [NCH-1:0]    cfg_en,
  input  logic [IDLE_W-1:0] cfg_idle_thr,
  input  logic [NCH-1:0]    ch_busy,
  input  logic [NCH-1:0]    ch_wreq,
  output logic [NCH-1:0]    ch_wack,
  output logic [NCH-1:0]    ch_gated,
  output logic [NCH-1:0]    clk_out
);

  localparam int unsigned      WCNT_W    = cg_wcnt_w(WAKE_CYC);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAKE_CYC - 1);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cg_state_e         state_q, state_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              gate_en_q;
    logic              wack_q;
    logic              gated_q;
    logic              wake_cause;

    // Anything that needs the clock, or forbids gating, counts as a reason to be clocked.
    assign wake_cause = ch_busy[i] | ch_wreq[i] | ~cfg_en[i] | test_mode;

    // Next-state and counter update.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
        CG_ON: begin
          if (!wake_cause) begin
            state_d = CG_IDLE;
            cnt_d   = '0;
          end
        end
        CG_IDLE: begin
          if (wake_cause) begin
            state_d = CG_ON;
          end else if (cnt_q >= cfg_idle_thr) begin
            state_d = CG_OFF;
          end else begin
            cnt_d = cnt_q + IDLE_W'(1);
          end
        end
        CG_OFF: begin
          if (wake_cause) begin
            state_d = CG_WAKE;
            wcnt_d  = '0;
          end
        end
        CG_WAKE: begin
          // Wake always runs to completion so the unit sees a settled clock.
          if (wcnt_q == WCNT_LAST) begin
            state_d = CG_ON;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      endcase
    end

    // State, counters and registered status derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= CG_ON;
        cnt_q     <= '0;
        wcnt_q    <= '0;
        gate_en_q <= 1'b1;
        wack_q    <= 1'b0;
        gated_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        wcnt_q    <= wcnt_d;
        gate_en_q <= (state_d != CG_OFF);
        wack_q    <= (state_d == CG_ON) || (state_d == CG_IDLE);
        gated_q   <= (state_d == CG_OFF);
      end
    end

    assign ch_wack[i]  = wack_q;
    assign ch_gated[i] = gated_q;

    e203_clkgate_cell u_cell (
      .clk_in    (clk),
      .test_mode (test_mode),
      .clock_en  (gate_en_q),
      .clk_out   (clk_out[i])
    );
  end

endmodule
